// File: rtl/cpu_types_pkg.sv
// Shared CPU/cache types: word type, instruction-cache address split, frame layout and FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int IIDX_W = 4;
   localparam int ITAG_W = 32 - IIDX_W - 2;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icachef_t;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      word_t             data;
   } icache_frame_t;

   typedef enum logic {
      IDLE,
      FETCH
   } icache_state_t;

endpackage

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: combinational hits, one-word refill
// on the iREN/iwait/iload channel on a miss.
//
// state | meaning
// IDLE  | serve hits; a missing fetch latches its word address and starts a refill
// FETCH | iREN held high for the latched address until iwait drops, then fill the frame
module icache_direct_mapped
   import cpu_types_pkg::*;
#(
   parameter int SETS   = 16,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload
);

   icache_state_t                  state, next_state;
   logic [ITAG_W+IIDX_W-1:0]       miss_addr;
   icache_frame_t                  frames [SETS];
   icachef_t                       faddr;
   icache_frame_t                  sel;
   logic                           hit;

   assign faddr = icachef_t'(imemaddr);

   always_comb begin
      next_state = state;
      sel        = frames[faddr.idx];
      hit        = 1'b0;
      ihit       = 1'b0;
      imemload   = '0;
      iREN       = 1'b0;
      iaddr      = '0;
      unique case (state)
         IDLE: begin
            hit = imemREN && sel.valid && (sel.tag == faddr.tag);
            if (hit) begin
               ihit     = 1'b1;
               imemload = sel.data;
            end else if (imemREN) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            // Refill is always for the latched address; fetch-side changes are ignored until IDLE.
            iREN  = 1'b1;
            iaddr = {miss_addr, 2'b00};
            if (!iwait) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         miss_addr <= '0;
         for (int i = 0; i < SETS; i++) frames[i] <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && imemREN && !hit)
            miss_addr <= {faddr.tag, faddr.idx};
         if (state == FETCH && !iwait)
            frames[miss_addr[IIDX_W-1:0]] <= '{valid: 1'b1,
                                                tag:   miss_addr[ITAG_W+IIDX_W-1:IIDX_W],
                                                data:  iload};
      end
   end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: a behavioural cache model predicts hit/miss,
// data and latency; a monitor and a memory responder check the DUT independently.
module tb_icache_direct_mapped;

   logic        CLK, nRST, imemREN, ihit, iREN, iwait;
   logic [31:0] imemaddr, imemload, iaddr, iload;

   icache_direct_mapped dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] data;
      int          lat;
      int          cyc0;
   } sb_t;

   sb_t         sb [$];
   logic [31:0] fq_addr [$];
   int          fq_wait [$];
   logic [31:0] ovr [logic [31:0]];
   bit          mvalid [16];
   logic [25:0] mtag [16];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (ovr.exists(w)) return ovr[w];
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Model: a miss queues a refill of the word address and installs it in its set.
   function automatic int model_access(input logic [31:0] a, input int w);
      int idx = int'(a[5:2]);
      if (mvalid[idx] && mtag[idx] == a[31:6]) return 0;
      fq_addr.push_back({a[31:2], 2'b00});
      fq_wait.push_back(w);
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[31:6];
      return 2 + w;
   endfunction

   task automatic start_req(input logic [31:0] a, input int w);
      sb_t e;
      @(posedge CLK); #1;
      imemREN  = 1'b1;
      imemaddr = a;
      e.lat  = model_access(a, w);
      e.data = memword(a);
      e.cyc0 = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_hit();
      for (int i = 0; i < 64; i++) begin
         @(negedge CLK);
         if (ihit) return;
      end
      chk("hit_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_read(input logic [31:0] a, input int w);
      start_req(a, w);
      wait_hit();
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (nRST) begin
         if (!imemREN && ihit) chk("ihit_without_req", {31'd0, ihit}, 32'd0);
         if (imemREN && ihit) begin
            if (sb.size() == 0) chk("unexpected_ihit", 32'd1, 32'd0);
            else begin
               sb_t e;
               e = sb.pop_front();
               chk("imemload", imemload, e.data);
               if (e.lat >= 0) chk("latency", 32'(cyc - e.cyc0), 32'(e.lat));
            end
         end
      end
   end

   // Memory responder: stalls each refill for the planned number of cycles, then supplies data.
   always @(negedge CLK) begin
      if (!nRST) iwait = 1'b1;
      else if (iREN) begin
         if (fq_addr.size() == 0) begin
            chk("unexpected_iren", 32'd1, 32'd0);
            iwait = 1'b0;
            iload = '0;
         end else begin
            chk("iaddr", iaddr, fq_addr[0]);
            if (fq_wait[0] > 0) begin
               fq_wait[0] = fq_wait[0] - 1;
               iwait = 1'b1;
            end else begin
               iwait = 1'b0;
               iload = memword(iaddr);
               void'(fq_addr.pop_front());
               void'(fq_wait.pop_front());
            end
         end
      end else iwait = 1'b1;
   end

   initial begin
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = '0;
      model_clear();
      ovr[32'h0000_0004] = 32'h2002_0005;
      ovr[32'h0000_0044] = 32'hAAAA_AAAA;
      repeat (2) @(negedge CLK);
      chk("rst_ihit", {31'd0, ihit}, 32'd0);
      chk("rst_iren", {31'd0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_imemload", imemload, 32'd0);
      imemREN = 1'b0;
      @(negedge CLK) nRST = 1'b1;

      do_read(32'h0000_0004, 3);            // cold miss, latency 5
      do_read(32'h0000_0004, 0);            // hit
      do_read(32'h0000_0007, 0);            // byte offset ignored
      do_read(32'h0000_0044, 1);            // conflict in set 1
      do_read(32'h0000_0004, 0);            // evicted, misses again

      // address change while refill is stalled
      start_req(32'h0000_0100, 3);
      @(negedge CLK); @(negedge CLK);
      @(posedge CLK); #1;
      begin
         sb_t e;
         imemaddr = 32'h0000_0200;
         sb.delete();
         e.lat  = model_access(32'h0000_0200, 1);
         e.lat  = -1;
         e.data = memword(32'h0000_0200);
         e.cyc0 = cyc;
         sb.push_back(e);
      end
      wait_hit();
      do_read(32'h0000_0100, 0);

      // sweep: fill every set, then re-read back to back
      for (int i = 0; i < 16; i++) do_read((32'd5 << 6) | (32'(i) << 2), i % 3);
      for (int i = 0; i < 16; i++) do_read((32'd5 << 6) | (32'(i) << 2) | 32'(i % 4), 0);

      // randomized traffic over a small tag space to mix hits and conflicts
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = ({30'($urandom_range(0, 3)), 6'd0}) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK); #1 imemREN = 1'b0;
         end
         do_read(a, int'($urandom_range(0, 3)));
      end

      // reset in the middle of a refill
      start_req(32'h0000_0080, 10);
      repeat (3) @(negedge CLK);
      @(posedge CLK); #1;
      nRST = 1'b0;
      #1;
      chk("midfetch_rst_iren", {31'd0, iREN}, 32'd0);
      chk("midfetch_rst_ihit", {31'd0, ihit}, 32'd0);
      imemREN = 1'b0;
      sb.delete(); fq_addr.delete(); fq_wait.delete();
      model_clear();
      @(negedge CLK) nRST = 1'b1;
      start_req(32'h0000_0040, 2);
      @(negedge CLK);
      chk("post_rst_miss_ihit", {31'd0, ihit}, 32'd0);
      chk("post_rst_miss_iren0", {31'd0, iREN}, 32'd0);
      @(negedge CLK);
      chk("post_rst_miss_iren1", {31'd0, iREN}, 32'd1);
      wait_hit();
      do_read(32'h0000_0040, 0);

      @(posedge CLK); #1 imemREN = 1'b0;
      repeat (3) @(negedge CLK);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("fills_drained", 32'(fq_addr.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
